ant_switch_allocator: RTL and testbench

//   Router stage directly downstream of ant_agent. Takes per-input one-hot output

---
 rtl/ant_switch_allocator.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ant_switch_allocator.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ant_switch_allocator.sv
// -----------------------------------------------------------------------------
// ant_switch_allocator
//
// Purpose
//   Switch-allocation stage that sits directly after ant_agent in the router.
//   Each input presents at most one one-hot output request per cycle. Every
//   output port runs its own round-robin arbiter over the eligible inputs and
//   checks downstream credit. The stage then drives registered grants,
//   input-buffer pops and crossbar selects one cycle after the request is
//   sampled. Packets are single-flit, so each input receives at most one grant
//   and each output drives at most one input per cycle.
//
// Configuration macro
//   ANT_PRIORITY_EN  When defined, and at least one eligible requester for an
//                    output carries an ant packet, only the ant requesters
//                    compete for that output. When undefined, i_ant is ignored
//                    and arbitration is pure round-robin.
//
// Parameters
//   N_PORTS  number of input ports (default 5)
//   M_PORTS  number of output ports (default 5); port M_PORTS-1 is local/eject
//   CREDITS  downstream buffer depth for each non-local output (default 4)
//   SEL_W    crossbar select width, derived from N_PORTS
//
// Ports
//   i_clk            clock
//   i_reset_n        asynchronous active-low reset
//   i_output_req     one-hot output request per input
//   i_req_val        request valid per input
//   i_ant            the head packet of the input is an ant packet
//   i_credit_return  one-cycle pulse per output: downstream freed one slot
//   o_grant          registered one-hot grant per input
//   o_input_pop      dequeue the head flit of the input (= |o_grant[i])
//   o_xbar_sel       index of the input that drives each output
//   o_xbar_val       the output is driven this cycle
//   o_credit_err     sticky: a credit was returned while the counter was full
//   o_req_err        sticky: a valid request was not one-hot
//
// Handshake
//   i_output_req[i] means something only when i_req_val[i] is 1. o_xbar_sel[o]
//   means something only when o_xbar_val[o] is 1, and reads 0 otherwise.
//   There is no ready signal back to the inputs. o_input_pop is the consume
//   indication. The head flit changes only in the cycle after the pop, so an
//   input that was granted last cycle is not eligible this cycle.
// -----------------------------------------------------------------------------
module ant_switch_allocator #(
    parameter int  N_PORTS = 5,
    parameter int  M_PORTS = 5,
    parameter int  CREDITS = 4,
    localparam int SEL_W   = $clog2(N_PORTS),
    localparam int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [0:N_PORTS-1][M_PORTS-1:0] i_output_req,
    input  logic [0:N_PORTS-1]              i_req_val,
    input  logic [0:N_PORTS-1]              i_ant,
    input  logic [0:M_PORTS-1]              i_credit_return,
    output logic [0:N_PORTS-1][M_PORTS-1:0] o_grant,
    output logic [0:N_PORTS-1]              o_input_pop,
    output logic [0:M_PORTS-1][SEL_W-1:0]   o_xbar_sel,
    output logic [0:M_PORTS-1]              o_xbar_val,
    output logic                            o_credit_err,
    output logic                            o_req_err
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [0:N_PORTS-1][M_PORTS-1:0] r_grant;
    logic [0:M_PORTS-1][SEL_W-1:0]   r_xbar_sel;
    logic [0:M_PORTS-1]              r_xbar_val;
    logic [SEL_W-1:0]                r_ptr [M_PORTS];
    logic                            r_credit_err;
    logic                            r_req_err;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [N_PORTS-1:0]              w_onehot;
    logic [N_PORTS-1:0]              w_bad_req;
    logic [N_PORTS-1:0]              w_busy;
    logic [N_PORTS-1:0]              w_ant_vec;
    logic                            w_credit_ok [M_PORTS];
    logic                            w_credit_ovf [M_PORTS];
    logic [N_PORTS-1:0]              w_elig [M_PORTS];
    logic [N_PORTS-1:0]              w_cand [M_PORTS];
    logic                            w_win_val [M_PORTS];
    logic [SEL_W-1:0]                w_win_idx [M_PORTS];
    logic [0:N_PORTS-1][M_PORTS-1:0] w_grant_nxt;
    logic                            w_any_bad;
    logic                            w_any_ovf;

    // ------------------------------------------------------------------
    // Per-input request qualification
    // ------------------------------------------------------------------
    always_comb begin
        w_onehot  = '0;
        w_bad_req = '0;
        w_busy    = '0;
        w_ant_vec = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            // A vector is one-hot when it is non-zero and has no second bit set.
            w_onehot[i]  = (i_output_req[i] != '0) &&
                           ((i_output_req[i] & (i_output_req[i] - M_PORTS'(1))) == '0);
            w_bad_req[i] = i_req_val[i] & ~w_onehot[i];
            // A grant last cycle means the buffer is popping now and the
            // request still shows the old head flit.
            w_busy[i]    = |r_grant[i];
            w_ant_vec[i] = i_ant[i];
        end
    end

    // ------------------------------------------------------------------
    // Eligibility matrix and optional ant filter
    // ------------------------------------------------------------------
    always_comb begin
        for (int o = 0; o < M_PORTS; o++) begin
            w_elig[o] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                w_elig[o][i] = i_req_val[i] & i_output_req[i][o] & w_onehot[i] &
                               ~w_busy[i] & w_credit_ok[o];
            end
`ifdef ANT_PRIORITY_EN
            // Ant packets take precedence. Normal requesters drop out of this
            // round if any eligible ant packet targets the same output.
            if ((w_elig[o] & w_ant_vec) != '0) begin
                w_cand[o] = w_elig[o] & w_ant_vec;
            end else begin
                w_cand[o] = w_elig[o];
            end
`else
            w_cand[o] = w_elig[o];
`endif
        end
    end

    // ------------------------------------------------------------------
    // Round-robin search per output: first candidate at or after r_ptr,
    // wrapping modulo N_PORTS.
    // ------------------------------------------------------------------
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        for (int o = 0; o < M_PORTS; o++) begin
            w_win_val[o] = 1'b0;
            w_win_idx[o] = '0;
            found        = 1'b0;
            for (int k = 0; k < N_PORTS; k++) begin
                idx = int'(r_ptr[o]) + k;
                if (idx >= N_PORTS) begin
                    idx = idx - N_PORTS;
                end
                if (!found && w_cand[o][idx]) begin
                    found        = 1'b1;
                    w_win_val[o] = 1'b1;
                    w_win_idx[o] = SEL_W'(idx);
                end
            end
        end
    end

    // Each input requests a single output, so the per-output winners never
    // collide on an input. The grant matrix is a direct decode of them.
    always_comb begin
        w_grant_nxt = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            for (int o = 0; o < M_PORTS; o++) begin
                w_grant_nxt[i][o] = w_win_val[o] && (w_win_idx[o] == SEL_W'(i));
            end
        end
    end

    // ------------------------------------------------------------------
    // Credit counters. Only non-local outputs have one. The eject port
    // always has room.
    // ------------------------------------------------------------------
    genvar go;
    generate
        for (go = 0; go < M_PORTS; go++) begin : g_out
            if (go < M_PORTS - 1) begin : g_cnt
                logic [CNT_W-1:0] r_credit;

                assign w_credit_ok[go]  = (r_credit != '0);
                // A return that arrives while the counter is full has
                // nowhere to go.
                assign w_credit_ovf[go] = i_credit_return[go] &&
                                          (r_credit == CNT_W'(CREDITS));

                always_ff @(posedge i_clk or negedge i_reset_n) begin
                    if (!i_reset_n) begin
                        r_credit <= CNT_W'(CREDITS);
                    end else begin
                        case ({w_win_val[go], i_credit_return[go]})
                            2'b10: r_credit <= r_credit - CNT_W'(1);
                            2'b01: begin
                                if (r_credit != CNT_W'(CREDITS)) begin
                                    r_credit <= r_credit + CNT_W'(1);
                                end
                            end
                            default: r_credit <= r_credit;
                        endcase
                    end
                end
            end else begin : g_local
                assign w_credit_ok[go]  = 1'b1;
                assign w_credit_ovf[go] = 1'b0;
            end
        end
    endgenerate

    // The local port has no credit counter. With ANT_PRIORITY_EN undefined,
    // i_ant is not used either.
    logic w_unused;
    assign w_unused = i_credit_return[M_PORTS-1] ^ (^w_ant_vec);

    // ------------------------------------------------------------------
    // Error reduction
    // ------------------------------------------------------------------
    always_comb begin
        w_any_bad = |w_bad_req;
        w_any_ovf = 1'b0;
        for (int o = 0; o < M_PORTS; o++) begin
            w_any_ovf = w_any_ovf | w_credit_ovf[o];
        end
    end

    // ------------------------------------------------------------------
    // Output registers, round-robin pointers, sticky errors
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_grant      <= '0;
            r_xbar_sel   <= '0;
            r_xbar_val   <= '0;
            r_credit_err <= 1'b0;
            r_req_err    <= 1'b0;
            for (int o = 0; o < M_PORTS; o++) begin
                r_ptr[o] <= '0;
            end
        end else begin
            r_grant      <= w_grant_nxt;
            r_credit_err <= r_credit_err | w_any_ovf;
            r_req_err    <= r_req_err | w_any_bad;
            for (int o = 0; o < M_PORTS; o++) begin
                r_xbar_val[o] <= w_win_val[o];
                // w_win_idx is already 0 when there is no winner.
                r_xbar_sel[o] <= w_win_idx[o];
                if (w_win_val[o]) begin
                    if (w_win_idx[o] == SEL_W'(N_PORTS - 1)) begin
                        r_ptr[o] <= '0;
                    end else begin
                        r_ptr[o] <= w_win_idx[o] + SEL_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        o_input_pop = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            o_input_pop[i] = |r_grant[i];
        end
    end

    assign o_grant      = r_grant;
    assign o_xbar_sel   = r_xbar_sel;
    assign o_xbar_val   = r_xbar_val;
    assign o_credit_err = r_credit_err;
    assign o_req_err    = r_req_err;

endmodule

// File: tb/tb_ant_switch_allocator.sv
// -----------------------------------------------------------------------------
// Testbench for ant_switch_allocator.
// The driver applies stimulus at the falling edge. A reference model then
// computes the response the stage must present after the next rising edge
// and pushes it into exp_q. A monitor pops one entry shortly after every
// rising edge and compares all outputs against it.
// -----------------------------------------------------------------------------
module tb_ant_switch_allocator;

    localparam int N  = 5;
    localparam int M  = 5;
    localparam int CR = 4;
    localparam int SW = $clog2(N);
    localparam int EXP_W = N*M + M + M*SW + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [0:N-1][M-1:0] req;
    logic [0:N-1]        val;
    logic [0:N-1]        ant;
    logic [0:M-1]        ret;
    logic [0:N-1][M-1:0] o_grant;
    logic [0:N-1]        o_input_pop;
    logic [0:M-1][SW-1:0] o_xbar_sel;
    logic [0:M-1]        o_xbar_val;
    logic                o_credit_err;
    logic                o_req_err;

    ant_switch_allocator dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_output_req   (req),
        .i_req_val      (val),
        .i_ant          (ant),
        .i_credit_return(ret),
        .o_grant        (o_grant),
        .o_input_pop    (o_input_pop),
        .o_xbar_sel     (o_xbar_sel),
        .o_xbar_val     (o_xbar_val),
        .o_credit_err   (o_credit_err),
        .o_req_err      (o_req_err)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [EXP_W-1:0] exp_q[$];

    // Reference model: credits left per output, next preferred input per
    // output, inputs granted last cycle, and the sticky error flags.
    int m_cred [M];
    int m_ptr  [M];
    bit m_prev [N];
    bit m_req_err;
    bit m_cred_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int o = 0; o < M; o++) begin
            m_cred[o] = CR;
            m_ptr[o]  = 0;
        end
        for (int i = 0; i < N; i++) m_prev[i] = 0;
        m_req_err  = 0;
        m_cred_err = 0;
    endfunction

    // Applies one cycle of the allocation rules to the current inputs and
    // queues the outputs they produce one cycle later.
    task automatic model_step();
        logic [0:N-1][M-1:0]  g;
        logic [0:M-1]         xv;
        logic [0:M-1][SW-1:0] xs;
        bit oh [N];
        bit el [N];
        bit any_ant;
        int best, best_d, d;
        g  = '0;
        xv = '0;
        xs = '0;
        for (int i = 0; i < N; i++) begin
            oh[i] = ($countones(req[i]) == 1);
            if (val[i] && !oh[i]) m_req_err = 1;
        end
        for (int o = 0; o < M; o++) begin
            any_ant = 0;
            for (int i = 0; i < N; i++) begin
                el[i] = val[i] && oh[i] && req[i][o] && !m_prev[i] &&
                        (o == M-1 || m_cred[o] > 0);
                if (el[i] && ant[i]) any_ant = 1;
            end
`ifdef ANT_PRIORITY_EN
            if (any_ant) begin
                for (int i = 0; i < N; i++) el[i] = el[i] && ant[i];
            end
`endif
            // The winner is the candidate nearest to the pointer, counting
            // forward with wrap.
            best   = -1;
            best_d = N;
            for (int i = 0; i < N; i++) begin
                if (el[i]) begin
                    d = (i - m_ptr[o] + N) % N;
                    if (d < best_d) begin
                        best_d = d;
                        best   = i;
                    end
                end
            end
            if (best >= 0) begin
                g[best][o] = 1'b1;
                xv[o]      = 1'b1;
                xs[o]      = SW'(best);
                m_ptr[o]   = (best + 1) % N;
            end
            if (o < M-1) begin
                if (ret[o] && m_cred[o] == CR) m_cred_err = 1;
                if (best >= 0 && !ret[o]) m_cred[o] = m_cred[o] - 1;
                else if (ret[o] && best < 0 && m_cred[o] < CR) m_cred[o] = m_cred[o] + 1;
            end
        end
        for (int i = 0; i < N; i++) m_prev[i] = |g[i];
        exp_q.push_back({g, xv, xs, m_req_err, m_cred_err});
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EXP_W-1:0]     e;
        logic [0:N-1][M-1:0]  e_g;
        logic [0:N-1]         e_pop;
        logic [0:M-1]         e_xv;
        logic [0:M-1][SW-1:0] e_xs;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                e_g   = e[EXP_W-1 -: N*M];
                e_xv  = e[M*SW+2 +: M];
                e_xs  = e[2 +: M*SW];
                for (int i = 0; i < N; i++) e_pop[i] = |e_g[i];
                check("grant",    64'(o_grant),    64'(e_g));
                check("pop",      64'(o_input_pop), 64'(e_pop));
                check("xbar_val", 64'(o_xbar_val), 64'(e_xv));
                check("xbar_sel", 64'(o_xbar_sel), 64'(e_xs));
                check("errors",   64'({o_req_err, o_credit_err}), 64'(e[1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        req = '0;
        val = '0;
        ant = '0;
        ret = '0;
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        check({name, "_grant"},    64'(o_grant),      64'd0);
        check({name, "_pop"},      64'(o_input_pop),  64'd0);
        check({name, "_xbar_val"}, 64'(o_xbar_val),   64'd0);
        check({name, "_xbar_sel"}, 64'(o_xbar_sel),   64'd0);
        check({name, "_errors"},   64'({o_req_err, o_credit_err}), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_inputs(input bit clean);
        for (int i = 0; i < N; i++) begin
            val[i] = ($urandom_range(0, 3) != 0);
            ant[i] = $urandom_range(0, 1);
            if (!clean && $urandom_range(0, 15) == 0) req[i] = M'($urandom);
            else req[i] = M'(1) << $urandom_range(0, M-1);
        end
        for (int o = 0; o < M; o++) begin
            if (clean) ret[o] = (o < M-1) && (m_cred[o] < CR) && ($urandom_range(0, 2) == 0);
            else ret[o] = ($urandom_range(0, 3) == 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        int exp_first;
        int exp_rr [4];
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        // Hold reset while requests are asserted.
        for (int i = 0; i < N; i++) req[i] = M'(1) << i;
        val = '1;
        repeat (3) @(negedge clk);
        check_idle("reset_hold");
        clear_inputs();
        rst_n = 1'b1;

        // Round-robin: inputs 0,1,2 all hold a request for output 2.
        for (int i = 0; i < 3; i++) begin
            req[i] = 5'b00100;
            val[i] = 1'b1;
        end
        exp_rr = '{0, 1, 2, 0};
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (c < 4) begin
                check("rr_valid", 64'(o_xbar_val[2]), 64'd1);
                check("rr_order", 64'(o_xbar_sel[2]), 64'(exp_rr[c]));
            end
        end

        // Pointer wrap: inputs 0 and 4 alternate on output 2.
        do_reset();
        req[0] = 5'b00100; val[0] = 1'b1;
        req[4] = 5'b00100; val[4] = 1'b1;
        exp_rr = '{0, 4, 0, 4};
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("rr_wrap", 64'(o_xbar_sel[2]), 64'(exp_rr[c]));
        end

        // Credits: continuous requests to output 1 with no returns.
        do_reset();
        req[0] = 5'b00010; val[0] = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            cnt += int'(o_input_pop[0]);
        end
        check("credit_stall_grants", 64'(cnt), 64'd4);
        ret[1] = 1'b1;
        cycle();
        ret[1] = 1'b0;
        check("credit_ret_cycle_pop", 64'(o_input_pop[0]), 64'd0);
        cycle();
        check("credit_ret_next_pop", 64'(o_input_pop[0]), 64'd1);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            cnt += int'(o_input_pop[0]);
        end
        check("credit_after_one_ret", 64'(cnt), 64'd0);
        // A return followed by a return that coincides with a grant
        // leaves one credit for a later grant.
        ret[1] = 1'b1;
        cycle();
        cycle();
        ret[1] = 1'b0;
        cnt = 1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            cnt += int'(o_input_pop[0]);
        end
        check("credit_grant_and_ret", 64'(cnt), 64'd2);

        // Local eject is never credit-stalled. A return at a full
        // counter raises the credit error.
        do_reset();
        req[3] = 5'b10000; val[3] = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            ret[1] = (c == 5);
            cycle();
            cnt += int'(o_input_pop[3]);
        end
        ret[1] = 1'b0;
        check("eject_grants", 64'(cnt), 64'd5);
        check("credit_err_set", 64'(o_credit_err), 64'd1);

        // A bad request is ignored and flagged.
        do_reset();
        req[2] = 5'b00110; val[2] = 1'b1;
        cycle();
        cycle();
        check("bad_req_no_pop", 64'(o_input_pop[2]), 64'd0);
        check("bad_req_err", 64'(o_req_err), 64'd1);

        // Ant versus normal packet on output 3 with the pointer at 0.
        do_reset();
        req[0] = 5'b01000; val[0] = 1'b1; ant[0] = 1'b0;
        req[4] = 5'b01000; val[4] = 1'b1; ant[4] = 1'b1;
`ifdef ANT_PRIORITY_EN
        exp_first = 4;
`else
        exp_first = 0;
`endif
        cycle();
        check("ant_first", 64'(o_xbar_sel[3]), 64'(exp_first));
        for (int c = 0; c < 4; c++) cycle();

        // Random traffic with clean credit returns, plus a reset in mid-flight.
        do_reset();
        for (int c = 0; c < 250; c++) begin
            random_inputs(1'b1);
            if (c == 120) begin
                model_step();
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                check_idle("mid_reset");
                exp_q.delete();
                model_reset();
                clear_inputs();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end

        // Unconstrained random traffic, including bad requests and over-returns.
        do_reset();
        for (int c = 0; c < 250; c++) begin
            random_inputs(1'b0);
            cycle();
        end
        clear_inputs();

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // A run that never ends stops here with a failure.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation did not complete at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
